pe_feeder: RTL and testbench

//  Sequencer feeding ProcessingEngine's data_in/weight_in/enable interface for one weight-stationary pass.

---
 rtl/pe_feeder.sv | 115 +++++++++++
 tb/tb_pe_feeder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: sequences one weight-stationary pass into the PE (weight row, then IN_ROW input rows)
// and tracks the PE pipeline so every result is flagged valid together with its row index.
//
// state  | meaning
// IDLE   | waiting for start; bases latched on start
// LOAD_W | two productive cycles: weight read, then weight capture
// STREAM | one input-row read per productive cycle
// DRAIN  | bubbles keep the PE clocked until the last result is consumed
// DONE   | one-cycle done pulse, busy low
module pe_feeder #(
  parameter int NUM_WIDTH  = 8,
  parameter int IN_COL     = 4,
  parameter int IN_ROW     = 4,
  parameter int ADDR_W     = 4,
  parameter int PE_LATENCY = 4,
  localparam int RW = IN_COL * NUM_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] data_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic              hold,
  output logic              data_rd_en,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [RW-1:0]     data_rdata,
  output logic              weight_rd_en,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [RW-1:0]     weight_rdata,
  output logic              pe_enable,
  output logic [RW-1:0]     pe_data_in,
  output logic [RW-1:0]     pe_weight_in,
  output logic              result_valid,
  output logic [ADDR_W-1:0] result_row,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IN_ROW - 1);

  state_t                state, state_nxt;
  logic                  adv, consume, ld_phase, v0, v1;
  logic [ADDR_W-1:0]     dbase_q, wbase_q, row_cnt, res_cnt;
  logic [PE_LATENCY-1:0] vs;

  assign busy         = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
  assign adv          = busy && !hold;
  assign pe_enable    = adv;
  assign done         = (state == DONE);
  assign weight_rd_en = adv && (state == LOAD_W) && !ld_phase;
  assign weight_addr  = wbase_q;
  assign data_rd_en   = adv && (state == STREAM);
  assign data_addr    = dbase_q + row_cnt;
  assign result_valid = vs[PE_LATENCY-1];
  assign result_row   = res_cnt;
  assign consume      = result_valid && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_W;
      LOAD_W:  if (adv && ld_phase) state_nxt = STREAM;
      STREAM:  if (adv && row_cnt == LAST_ROW) state_nxt = DRAIN;
      DRAIN:   if (consume && res_cnt == LAST_ROW) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything below advances only on productive cycles, so a hold freezes the
  // capture pipeline and the PE tracker in step with the PE itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbase_q      <= '0;
      wbase_q      <= '0;
      row_cnt      <= '0;
      res_cnt      <= '0;
      ld_phase     <= 1'b0;
      v0           <= 1'b0;
      v1           <= 1'b0;
      vs           <= '0;
      pe_data_in   <= '0;
      pe_weight_in <= '0;
    end else begin
      if (state == IDLE && start) begin
        dbase_q  <= data_base;
        wbase_q  <= weight_base;
        row_cnt  <= '0;
        res_cnt  <= '0;
        ld_phase <= 1'b0;
      end
      if (state == DONE) res_cnt <= '0;
      if (adv) begin
        if (state == LOAD_W) begin
          ld_phase <= 1'b1;
          if (ld_phase) pe_weight_in <= weight_rdata;
        end
        if (data_rd_en) row_cnt <= row_cnt + ADDR_W'(1);
        if (consume) res_cnt <= res_cnt + ADDR_W'(1);
        v0         <= data_rd_en;
        v1         <= v0;
        pe_data_in <= v0 ? data_rdata : '0;
        vs         <= {vs[PE_LATENCY-2:0], v1};
      end
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: scratchpad and PE behavioural models plus a reference model that
// predicts each cycle from the count of productive (busy, un-held) cycles since start.
module tb_pe_feeder;

  localparam int ROWS   = 4;
  localparam int PE_LAT = 4;
  localparam int ISSUE0 = 2;                  // productive cycles before the first row read
  localparam int RES0   = ISSUE0 + 2 + PE_LAT; // productive cycles before row 0 result is valid

  logic        clk = 1'b0;
  logic        reset, start, hold;
  logic [3:0]  data_base, weight_base;
  logic        data_rd_en, weight_rd_en, pe_enable, result_valid, busy, done;
  logic [3:0]  data_addr, weight_addr, result_row;
  logic [31:0] data_rdata = '0, weight_rdata = '0, pe_data_in, pe_weight_in;

  logic [31:0] mem_d [16];
  logic [31:0] mem_w [16];
  logic [17:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;

  bit          hold_sched  [64];
  bit          start_sched [64];
  logic [5:0]  obs_ctl [64], exp_ctl [64];   // {busy, done, pe_enable, weight_rd_en, data_rd_en, result_valid}
  logic [3:0]  obs_daddr [64], exp_daddr [64], obs_waddr [64], obs_row [64], exp_row [64];
  logic [17:0] obs_pe [64], exp_pe [64];

  int n_total = 0;
  int n_pass  = 0;

  pe_feeder dut (
    .clk(clk), .reset(reset), .start(start), .data_base(data_base), .weight_base(weight_base),
    .hold(hold), .data_rd_en(data_rd_en), .data_addr(data_addr), .data_rdata(data_rdata),
    .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
    .pe_enable(pe_enable), .pe_data_in(pe_data_in), .pe_weight_in(pe_weight_in),
    .result_valid(result_valid), .result_row(result_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] dot(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return 18'(s);
  endfunction

  always @(posedge clk) begin
    if (data_rd_en)   data_rdata   <= mem_d[data_addr];
    if (weight_rd_en) weight_rdata <= mem_w[weight_addr];
    if (pe_enable) begin
      p0 <= dot(pe_data_in, pe_weight_in);
      p1 <= p0;
      p2 <= p1;
      p3 <= p2;
    end
  end

  task automatic clear_sched();
    for (int i = 0; i < 64; i++) begin
      hold_sched[i]  = 1'b0;
      start_sched[i] = 1'b0;
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = $urandom;
      mem_w[i] = $urandom;
    end
  endtask

  // Reference: busy until RES0+ROWS productive cycles have elapsed, then one done cycle.
  task automatic model_pass(input logic [3:0] db, input logic [3:0] wb, output int dcyc);
    int n, c;
    bit h;
    logic [3:0] idx;
    for (int i = 0; i < 64; i++) begin
      exp_ctl[i] = '0; exp_daddr[i] = '0; exp_row[i] = '0; exp_pe[i] = '0;
    end
    n = 0;
    c = 1;
    while (n < RES0 + ROWS && c < 62) begin
      h = hold_sched[c];
      exp_ctl[c] = {1'b1, 1'b0, !h, (n == 0) && !h,
                    (n >= ISSUE0 && n < ISSUE0 + ROWS) && !h, (n >= RES0 && n < RES0 + ROWS)};
      exp_daddr[c] = db + 4'(n - ISSUE0);
      exp_row[c]   = 4'(n - RES0);
      idx          = db + 4'(n - RES0);
      exp_pe[c]    = dot(mem_d[idx], mem_w[wb]);
      if (!h) n++;
      c++;
    end
    exp_ctl[c] = 6'b010000;
    dcyc = c;
  endtask

  task automatic run_pass(input logic [3:0] db, input logic [3:0] wb, input int ncyc);
    data_base   = db;
    weight_base = wb;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || start_sched[c];
      hold  = hold_sched[c];
      @(negedge clk);
      obs_ctl[c]   = {busy, done, pe_enable, weight_rd_en, data_rd_en, result_valid};
      obs_daddr[c] = data_addr;
      obs_waddr[c] = weight_addr;
      obs_row[c]   = result_row;
      obs_pe[c]    = p3;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({busy, done, pe_enable, data_rd_en, weight_rd_en, result_valid, result_row,
         data_addr, weight_addr, pe_data_in, pe_weight_in} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b drd=%b wrd=%b rv=%b row=%h pd=%h pw=%h, want all 0",
               busy, done, pe_enable, data_rd_en, weight_rd_en, result_valid, result_row, pe_data_in, pe_weight_in);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    hold  = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, done, pe_enable, data_rd_en, weight_rd_en} !== 5'b0)
      $display("FAIL reset_idle_hold: got %b want 00000", {busy, done, pe_enable, data_rd_en, weight_rd_en});
    else n_pass++;
    hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int dcyc, dobs;
    clear_sched();
    randomize_mem();
    mem_w[0] = 32'h01020304;
    for (int r = 0; r < 4; r++) mem_d[r] = {4{8'(r + 1)}};
    model_pass(4'h0, 4'h0, dcyc);
    run_pass(4'h0, 4'h0, dcyc + 1);
    dobs = -1;
    for (int c = 0; c <= dcyc; c++) begin
      n_total++;
      if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL basic_ctl cyc %0d: got %b want %b", c, obs_ctl[c], exp_ctl[c]);
      else n_pass++;
      if (exp_ctl[c][0]) begin
        n_total++;
        if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
          $display("FAIL basic_result cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                   c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
        else n_pass++;
      end
      if (exp_ctl[c][1]) begin
        n_total++;
        if (obs_daddr[c] !== exp_daddr[c]) $display("FAIL basic_daddr cyc %0d: got %h want %h", c, obs_daddr[c], exp_daddr[c]);
        else n_pass++;
      end
      if (obs_ctl[c][4]) dobs = c;
    end
    for (int c = 9; c <= 12; c++) begin
      n_total++;
      if (obs_ctl[c][0] !== 1'b1 || obs_pe[c] !== 18'(10 * (c - 8)))
        $display("FAIL basic_pe_value cyc %0d: got rv=%b pe=%0d want rv=1 pe=%0d", c, obs_ctl[c][0], obs_pe[c], 10 * (c - 8));
      else n_pass++;
    end
    n_total++;
    if (dobs !== 13) $display("FAIL basic_done_cycle: got %0d want 13", dobs);
    else n_pass++;
    n_total++;
    if (pe_weight_in !== 32'h01020304) $display("FAIL basic_weight: got %h want 01020304", pe_weight_in);
    else n_pass++;
  endtask

  task automatic test_stall();
    int dcyc, dobs;
    clear_sched();
    randomize_mem();
    for (int c = 5; c < 8; c++) hold_sched[c] = 1'b1;
    model_pass(4'h3, 4'h9, dcyc);
    run_pass(4'h3, 4'h9, dcyc + 1);
    dobs = -1;
    for (int c = 0; c <= dcyc; c++) begin
      n_total++;
      if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL stall_ctl cyc %0d: got %b want %b", c, obs_ctl[c], exp_ctl[c]);
      else n_pass++;
      if (exp_ctl[c][0]) begin
        n_total++;
        if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
          $display("FAIL stall_result cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                   c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
        else n_pass++;
      end
      if (obs_ctl[c][4]) dobs = c;
    end
    n_total++;
    if (dobs !== 16) $display("FAIL stall_done_cycle: got %0d want 16", dobs);
    else n_pass++;
  endtask

  task automatic test_hold_result();
    int dcyc, consumed;
    clear_sched();
    randomize_mem();
    hold_sched[10] = 1'b1;
    hold_sched[11] = 1'b1;
    model_pass(4'h5, 4'h2, dcyc);
    run_pass(4'h5, 4'h2, dcyc + 1);
    consumed = 0;
    for (int c = 0; c <= dcyc; c++) begin
      n_total++;
      if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL holdres_ctl cyc %0d: got %b want %b", c, obs_ctl[c], exp_ctl[c]);
      else n_pass++;
      if (exp_ctl[c][0]) begin
        n_total++;
        if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
          $display("FAIL holdres_result cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                   c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
        else n_pass++;
      end
      if (obs_ctl[c][0] && !hold_sched[c]) consumed++;
    end
    n_total++;
    if (consumed !== ROWS) $display("FAIL holdres_consumed: got %0d want %0d", consumed, ROWS);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int dcyc, ndone;
    clear_sched();
    randomize_mem();
    start_sched[4]  = 1'b1;
    start_sched[13] = 1'b1;
    model_pass(4'h7, 4'h4, dcyc);
    run_pass(4'h7, 4'h4, dcyc + 3);
    ndone = 0;
    for (int c = 0; c < dcyc + 3; c++) begin
      n_total++;
      if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL startign_ctl cyc %0d: got %b want %b", c, obs_ctl[c], exp_ctl[c]);
      else n_pass++;
      if (obs_ctl[c][4]) ndone++;
    end
    n_total++;
    if (ndone !== 1) $display("FAIL startign_done_count: got %0d want 1", ndone);
    else n_pass++;
  endtask

  task automatic test_abort_restart();
    int dcyc;
    clear_sched();
    randomize_mem();
    run_pass(4'h0, 4'h1, 6);
    reset = 1'b0;
    #1;
    n_total++;
    if ({busy, done, pe_enable, data_rd_en, weight_rd_en, result_valid, result_row,
         data_addr, weight_addr, pe_data_in, pe_weight_in} !== '0)
      $display("FAIL abort_outputs: got busy=%b en=%b drd=%b row=%h daddr=%h pd=%h pw=%h, want all 0",
               busy, pe_enable, data_rd_en, result_row, data_addr, pe_data_in, pe_weight_in);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL abort_no_done %0d: got busy=%b done=%b want 0 0", i, busy, done);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    randomize_mem();
    model_pass(4'hE, 4'h6, dcyc);
    run_pass(4'hE, 4'h6, dcyc + 1);
    for (int c = 0; c <= dcyc; c++) begin
      n_total++;
      if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL restart_ctl cyc %0d: got %b want %b", c, obs_ctl[c], exp_ctl[c]);
      else n_pass++;
      if (exp_ctl[c][1]) begin
        n_total++;
        if (obs_daddr[c] !== exp_daddr[c]) $display("FAIL restart_daddr cyc %0d: got %h want %h", c, obs_daddr[c], exp_daddr[c]);
        else n_pass++;
      end
      if (exp_ctl[c][0]) begin
        n_total++;
        if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
          $display("FAIL restart_result cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                   c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcyc;
    logic [3:0] wb;
    clear_sched();
    randomize_mem();
    for (int p = 0; p < 2; p++) begin
      wb = (p == 0) ? 4'hA : 4'hB;
      model_pass(4'h8, wb, dcyc);
      run_pass(4'h8, wb, dcyc + 1);
      for (int c = 0; c <= dcyc; c++) begin
        n_total++;
        if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL b2b_ctl pass %0d cyc %0d: got %b want %b", p, c, obs_ctl[c], exp_ctl[c]);
        else n_pass++;
        if (exp_ctl[c][2]) begin
          n_total++;
          if (obs_waddr[c] !== wb) $display("FAIL b2b_waddr pass %0d: got %h want %h", p, obs_waddr[c], wb);
          else n_pass++;
        end
        if (exp_ctl[c][0]) begin
          n_total++;
          if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
            $display("FAIL b2b_result pass %0d cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                     p, c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
          else n_pass++;
        end
      end
      n_total++;
      if (pe_weight_in !== mem_w[wb]) $display("FAIL b2b_weight pass %0d: got %h want %h", p, pe_weight_in, mem_w[wb]);
      else n_pass++;
      mem_w[4'hB] = $urandom;
    end
  endtask

  task automatic test_random();
    int dcyc;
    logic [3:0] db, wb;
    for (int it = 0; it < 6; it++) begin
      clear_sched();
      randomize_mem();
      db = 4'($urandom);
      wb = 4'($urandom);
      for (int c = 1; c < 40; c++) begin
        hold_sched[c]  = ($urandom_range(0, 3) == 0);
        start_sched[c] = ($urandom_range(0, 7) == 0);
      end
      model_pass(db, wb, dcyc);
      run_pass(db, wb, dcyc + 1);
      for (int c = 0; c <= dcyc; c++) begin
        n_total++;
        if (obs_ctl[c] !== exp_ctl[c]) $display("FAIL rand_ctl it %0d cyc %0d: got %b want %b", it, c, obs_ctl[c], exp_ctl[c]);
        else n_pass++;
        if (exp_ctl[c][1]) begin
          n_total++;
          if (obs_daddr[c] !== exp_daddr[c]) $display("FAIL rand_daddr it %0d cyc %0d: got %h want %h", it, c, obs_daddr[c], exp_daddr[c]);
          else n_pass++;
        end
        if (exp_ctl[c][0]) begin
          n_total++;
          if ({obs_row[c], obs_pe[c]} !== {exp_row[c], exp_pe[c]})
            $display("FAIL rand_result it %0d cyc %0d: got row %0d pe %0d want row %0d pe %0d",
                     it, c, obs_row[c], obs_pe[c], exp_row[c], exp_pe[c]);
          else n_pass++;
        end
      end
      n_total++;
      if (pe_weight_in !== mem_w[wb]) $display("FAIL rand_weight it %0d: got %h want %h", it, pe_weight_in, mem_w[wb]);
      else n_pass++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    hold        = 1'b0;
    data_base   = '0;
    weight_base = '0;
    randomize_mem();
    test_reset();
    test_basic();
    test_stall();
    test_hold_result();
    test_start_ignored();
    test_abort_restart();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
